// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic skew feeder.
//   state_e      : feeder FSM state encoding (also exported on the debug port)
//   DEF_N        : default array dimension
//   DRAIN_CYCLES : drain length for the default array dimension
//   drain_cycles : drain length for an arbitrary array dimension
//   lane_lsb     : LSB of lane <lane> in a packed vector of <width>-bit lanes
package systolic_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  localparam int DEF_N        = 4;
  localparam int DRAIN_CYCLES = 2 * DEF_N - 1;

  // PE(i,j) sees a beat i+j cycles after lane 0 does, plus one register stage,
  // so the last product of a tile lands 2N-1 cycles after the last beat.
  function automatic int drain_cycles(input int n);
    return 2 * n - 1;
  endfunction

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/systolic_skew_feeder_skew_line.sv
// One lane of diagonal skew: a plain shift chain of DEPTH registers.
//   clk, rst : clock, synchronous active-high reset (clears every stage)
//   d        : head input, shifted in every cycle
//   q        : tail output, d delayed by DEPTH cycles
module skew_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Upstream feeder for an N x N systolic MAC array.
// Accepts one A column and one B row per beat, skews lane i by i+1 register
// stages on both edges, and sequences a tile: CLEAR -> STREAM -> DRAIN -> DONE.
//   clk, rst            : clock, synchronous active-high reset
//   start, k_len        : tile start pulse (IDLE only) and beat count
//   in_valid / in_ready : beat handshake
//   in_a, in_b          : A column / B row, lane i at [i*WIDTH +: WIDTH]
//   west_out, north_out : skewed array edges
//   pe_clr              : one-cycle accumulator clear for the array
//   busy, done          : FSM not idle / one-cycle tile completion pulse
//   dbg_state           : current FSM state
//
// Handshake: a beat transfers in any cycle where in_valid && in_ready are both
// high at the clock edge; in_ready does not depend on in_valid, and in_valid
// in a cycle without in_ready consumes nothing.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  parameter int KW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KW-1:0]    k_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*WIDTH-1:0] in_a,
  input  logic [N*WIDTH-1:0] in_b,
  output logic [N*WIDTH-1:0] west_out,
  output logic [N*WIDTH-1:0] north_out,
  output logic             pe_clr,
  output logic             busy,
  output logic             done,
  output state_e           dbg_state
);

  localparam int DRAIN_CYC = drain_cycles(N);
  localparam int DW        = $clog2(2 * N);

  state_e          state_q, state_d;
  logic [KW-1:0]   k_len_q, k_len_d;
  logic [KW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
  logic            accept;
  logic [N*WIDTH-1:0] head_a, head_b;

  assign accept = in_valid && in_ready;

  // Both edges bubble on the same condition, which keeps them aligned.
  assign head_a = accept ? in_a : '0;
  assign head_b = accept ? in_b : '0;

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_line #(.DEPTH(i + 1), .WIDTH(WIDTH)) u_west (
      .clk (clk),
      .rst (rst),
      .d   (head_a[lane_lsb(i, WIDTH) +: WIDTH]),
      .q   (west_out[lane_lsb(i, WIDTH) +: WIDTH])
    );
    skew_line #(.DEPTH(i + 1), .WIDTH(WIDTH)) u_north (
      .clk (clk),
      .rst (rst),
      .d   (head_b[lane_lsb(i, WIDTH) +: WIDTH]),
      .q   (north_out[lane_lsb(i, WIDTH) +: WIDTH])
    );
  end

  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    beat_cnt_d  = beat_cnt_q;
    drain_cnt_d = drain_cnt_q;
    in_ready    = 1'b0;
    pe_clr      = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          k_len_d = k_len;
          state_d = (k_len == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        pe_clr     = 1'b1;
        beat_cnt_d = '0;
        state_d    = S_STREAM;
      end
      S_STREAM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          beat_cnt_d = beat_cnt_q + KW'(1);
          // Comparing the incremented value keeps k_len = 2^KW-1 in range.
          if (beat_cnt_q + KW'(1) == k_len_q) begin
            state_d     = S_DRAIN;
            drain_cnt_d = DW'(DRAIN_CYC - 1);
          end
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == '0) state_d = S_DONE;
        else                   drain_cnt_d = drain_cnt_q - DW'(1);
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_len_q     <= '0;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      beat_cnt_q  <= beat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
Upstream feeder for the N x N systolic MAC array built from the PE block (inp_north/inp_west in, outp_south/outp_east pass-through, 2*WIDTH accumulator).
- Accepts one A-column vector and one B-row vector per handshake beat.
- Drives both array edges with the diagonal skew the array needs: lane i is delayed i cycles.
- Sequences a tile: clears the PE accumulators, streams K beats, drains, then pulses done.

Parameters:
N, 4, array dimension (lanes per edge)
WIDTH, 16, operand width (matches PE WIDTH)
KW, 8, width of the tile-length field k_len

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  tile start pulse; sampled only in IDLE
k_len  in  KW  beats in tile; latched on accepted start
in_valid  in  1  upstream beat valid
in_ready  out  1  beat accepted when in_valid && in_ready
in_a  in  N*WIDTH  A column; lane i at [i*WIDTH +: WIDTH]
in_b  in  N*WIDTH  B row; lane j at [j*WIDTH +: WIDTH]
west_out  out  N*WIDTH  to inp_west of PE(i,0), lane i
north_out  out  N*WIDTH  to inp_north of PE(0,j), lane j
pe_clr  out  1  accumulator clear to array rst, one-cycle pulse
busy  out  1  FSM not in IDLE
done  out  1  one-cycle pulse; all tile products accumulated

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: all outputs 0, all skew registers 0, FSM in IDLE, counters 0.
- Skew lines:
  - Lane i of each edge is a shift chain of i+1 registers.
  - Chains shift every cycle in every state.
  - Head input is the lane value on an accepted beat, else 0 (bubble).
  - A beat accepted in cycle t appears on west_out/north_out lane i in cycle t+1+i.
  - A and B always bubble together, so the edges stay aligned.
  - Operands pass bit-exact; no sign handling (PE treats them as signed).
- FSM states: IDLE, CLEAR, STREAM, DRAIN, DONE.
  - IDLE: busy=0, in_ready=0. On start, latch k_len.
    - k_len==0: go to DONE (no pe_clr).
    - Otherwise go to CLEAR.
  - CLEAR: one cycle, pe_clr=1, in_ready=0. Then STREAM; beat counter = 0.
  - STREAM: in_ready=1. Each accepted beat increments the counter. A cycle without in_valid inserts a bubble. The beat that makes counter==k_len moves to DRAIN next cycle.
  - DRAIN: in_ready=0, lasts exactly 2N-1 cycles (down-counter), then DONE.
    - Basis: PE(i,j) accumulates the cycle-t beat at the end of cycle t+1+i+j.
    - Maximum is t+2N-1.
  - DONE: done=1 for one cycle, then IDLE. If the last beat was accepted in cycle t, done is high in cycle t+2N.
- Boundary conditions:
  - start outside IDLE is ignored.
  - in_valid outside STREAM is ignored; nothing is consumed.
  - k_len=2^KW-1 must work (counter width KW).
  - rst at any point, including mid-STREAM: the next cycle matches the reset state; in-flight skew data is discarded.
  - start in the same cycle as rst: rst wins.
- Latency and throughput:
  - Beat-to-edge latency 1+i.
  - One beat per cycle in STREAM.
  - Per-tile overhead is 1 CLEAR + 2N-1 DRAIN + 1 DONE cycles.

Decomposition:
- Shared package systolic_pkg: FSM state encoding; localparam DRAIN_CYCLES = 2*N-1; lane slice helper.
- Sub-module skew_line (parameters DEPTH, WIDTH): one per-lane shift chain; instantiated 2N times via generate with DEPTH=i+1.
- FSM and counters live in the top module.

Test Plan:
(N=4, WIDTH=16)
- Reset: hold rst 2 cycles -> west_out=north_out=0, in_ready=0, busy=0, done=0, pe_clr=0.
- Single beat: start, k_len=1 -> pe_clr high the cycle after start. Then accept in_a lanes {1,2,3,4} and in_b lanes {5,6,7,8} at cycle t -> west lane i carries 1+i only in cycle t+1+i (lane3=4 at t+4), north lane j carries 5+j at t+1+j, all else 0. done at t+8.
- Bubble: k_len=3 with in_valid low for one cycle between beats 1 and 2 -> every lane shows a zero slot at the matching skewed cycle. With a 4x4 PE array attached, PE(3,3).result equals the 3-term dot product when done fires.
- Backpressure: in_valid held high through CLEAR and DRAIN -> in_ready=0 there, beat count stays k_len, exactly k_len beats are consumed.
- k_len=0: start -> busy for one cycle, done the cycle after start, pe_clr never asserted.
- Reset mid-STREAM plus signed data: in_a lane0=16'hFFFB. rst asserted after 2 of 4 beats -> next cycle all outputs 0 and busy=0. A new tile started afterwards completes normally; 16'hFFFB appears unchanged on west lane 0.
